// File: rtl/add_approx_pkg.sv
// Shared definitions for the approximate-adder pipeline.
//
// Contents:
//   SUM_MAX_W - storage width of the sum fields in the stage payload. It is
//               wide enough for the largest legal operand width plus carry-out.
//   mode_e    - approximation mode encodings.
//   stage_t   - one pipeline stage entry: valid flag, the approximate sum and
//               the exact sum carried alongside it.
package add_approx_pkg;

    localparam int SUM_MAX_W = 65;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_LOR   = 2'd1,
        MODE_TRUNC = 2'd2,
        MODE_SAT   = 2'd3
    } mode_e;

    // Sum fields are stored at the maximum width and zero-extended. This lets
    // a single non-parameterised package type serve every legal WIDTH.
    typedef struct packed {
        logic                 valid;
        logic [SUM_MAX_W-1:0] approx;
        logic [SUM_MAX_W-1:0] exact;
    } stage_t;

endpackage

// File: rtl/add_approx_core.sv
// Combinational approximate adder.
//
// Ports:
//   a, b  (in,  WIDTH)   unsigned operands
//   mode  (in,  2)       approximation mode (see add_approx_pkg::mode_e)
//   sum   (out, WIDTH+1) approximate sum including carry-out
//   exact (out, WIDTH+1) exact a+b, used downstream for error tracking
//
// The low APPROX_LSB bits are approximated. The upper part is always a true
// addition. Its carry-in is one of two things:
//   - a guess from the top approximated bit pair (lower-OR mode);
//   - zero (truncate and saturate-low modes).
module add_approx_core
    import add_approx_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int APPROX_LSB = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   exact
);

    assign exact = {1'b0, a} + {1'b0, b};

    generate
        if (APPROX_LSB == 0) begin : gNoApprox
            // Nothing to approximate, so every mode reduces to the exact sum.
            logic unusedMode;
            assign unusedMode = ^mode;
            assign sum        = exact;
        end else begin : gApprox
            localparam int L = APPROX_LSB;
            localparam int H = WIDTH - APPROX_LSB;

            mode_e        modeSel;
            logic         carryIn;
            logic [L-1:0] lowBits;
            logic [H:0]   hiSum;

            assign modeSel = mode_e'(mode);

            // Choose the low-part pattern and the carry injected into the
            // exact upper adder for the selected mode.
            always_comb begin
                carryIn = 1'b0;
                lowBits = '0;
                case (modeSel)
                    MODE_LOR: begin
                        carryIn = a[L-1] & b[L-1];
                        lowBits = a[L-1:0] | b[L-1:0];
                    end
                    MODE_TRUNC: lowBits = '0;
                    MODE_SAT:   lowBits = '1;
                    default:    lowBits = '0;
                endcase
            end

            assign hiSum = {1'b0, a[WIDTH-1:L]} + {1'b0, b[WIDTH-1:L]}
                         + {{H{1'b0}}, carryIn};

            assign sum = (modeSel == MODE_EXACT) ? exact : {hiSum, lowBits};
        end
    endgenerate

endmodule

// File: rtl/add_approx_pipe.sv
// Pipelined approximate adder with valid/ready handshaking and a
// worst-case error monitor.
//
// Ports:
//   clk, rst   (in)            clock, synchronous active-high reset
//   in_valid   (in)            operands/mode valid this cycle
//   in_ready   (out)           pipeline can accept this cycle
//   a, b       (in,  WIDTH)    unsigned operands
//   mode       (in,  2)        approximation mode, sampled with the operands
//   out_valid  (out)           sum is valid
//   out_ready  (in)            downstream accepts sum
//   sum        (out, WIDTH+1)  approximate result including carry-out
//   err_max    (out, WIDTH+1)  largest |exact - sum| delivered since clear
//   err_clr    (in)            synchronous clear of err_max
//
// The combinational core sits in front of STAGES register stages that move
// in lockstep. The whole pipe stalls only when the last stage holds a valid
// result that downstream refuses. Bubbles move through like normal entries.
module add_approx_pipe
    import add_approx_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int APPROX_LSB = 8,
    parameter int STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   err_max,
    input  logic             err_clr
);

    logic [WIDTH:0]       coreSum;
    logic [WIDTH:0]       coreExact;
    logic                 pipeEn;
    logic                 deliver;
    logic [SUM_MAX_W-1:0] errCur;
    stage_t               lastStage;

    stage_t         stage_q [STAGES];
    stage_t         stage_d [STAGES];
    logic [WIDTH:0] errMax_q;
    logic [WIDTH:0] errMax_d;

    add_approx_core #(
        .WIDTH      (WIDTH),
        .APPROX_LSB (APPROX_LSB)
    ) uCore (
        .a     (a),
        .b     (b),
        .mode  (mode),
        .sum   (coreSum),
        .exact (coreExact)
    );

    assign lastStage = stage_q[STAGES-1];
    assign out_valid = lastStage.valid;
    assign pipeEn    = !out_valid | out_ready;
    assign in_ready  = pipeEn;
    assign deliver   = out_valid & out_ready;
    assign sum       = lastStage.approx[WIDTH:0];
    assign err_max   = errMax_q;

    // Advance every stage together when the output is free. Otherwise hold
    // them all, so nothing in flight is lost or duplicated.
    always_comb begin
        stage_d = stage_q;
        if (pipeEn) begin
            stage_d[0].valid  = in_valid;
            stage_d[0].approx = SUM_MAX_W'(coreSum);
            stage_d[0].exact  = SUM_MAX_W'(coreExact);
            for (int i = 1; i < STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Absolute error of the entry at the output. The approximation can
    // overshoot (saturate-low, lower-OR), so both directions are handled.
    always_comb begin
        if (lastStage.exact >= lastStage.approx) begin
            errCur = lastStage.exact - lastStage.approx;
        end else begin
            errCur = lastStage.approx - lastStage.exact;
        end
    end

    // Error monitor: a clear that coincides with a delivery restarts the
    // running maximum from that delivery rather than from zero.
    always_comb begin
        errMax_d = errMax_q;
        if (err_clr) begin
            errMax_d = deliver ? errCur[WIDTH:0] : '0;
        end else if (deliver && (errCur > SUM_MAX_W'(errMax_q))) begin
            errMax_d = errCur[WIDTH:0];
        end
    end

    // State registers. Reset wipes the payloads too, so sum reads zero
    // afterwards and in-flight transactions vanish.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            errMax_q <= '0;
        end else begin
            stage_q  <= stage_d;
            errMax_q <= errMax_d;
        end
    end

endmodule

// File: tb/tb_add_approx_pipe.sv
// Self-checking bench for add_approx_pipe (WIDTH=16, APPROX_LSB=8, STAGES=2).
// Accepted transactions push their expected approximate and exact sums to a
// queue. Deliveries pop and compare them. A reference error maximum is kept
// alongside.
module tb_add_approx_pipe;

    localparam int WIDTH      = 16;
    localparam int APPROX_LSB = 8;
    localparam int STAGES     = 2;
    localparam int SW         = WIDTH + 1;

    typedef struct {
        logic [WIDTH:0] sum;
        logic [WIDTH:0] exact;
    } expect_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   err_max;
    logic             err_clr;

    expect_t        sbQueue[$];
    logic [WIDTH:0] errModel;
    int             assertCount;
    int             failCount;
    logic           obsOutValid;
    logic           obsInReady;
    logic [WIDTH:0] obsSum;
    logic           lastAccepted;
    logic           sawInReadyLow;

    add_approx_pipe #(
        .WIDTH      (WIDTH),
        .APPROX_LSB (APPROX_LSB),
        .STAGES     (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .err_max   (err_max),
        .err_clr   (err_clr)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [WIDTH:0] observed,
                               input logic [WIDTH:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model of the approximate sum, written from the mode
    // definitions.
    function automatic logic [WIDTH:0] modelSum(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [1:0] m);
        logic [WIDTH:0] ex;
        logic [WIDTH:0] hi;
        logic [WIDTH:0] mask;
        logic [WIDTH:0] res;
        ex   = SW'(x) + SW'(y);
        mask = (SW'(1) << APPROX_LSB) - SW'(1);
        hi   = SW'(x >> APPROX_LSB) + SW'(y >> APPROX_LSB);
        res  = ex;
        case (m)
            2'd1: begin
                hi  = hi + SW'(x[APPROX_LSB-1] & y[APPROX_LSB-1]);
                res = (hi << APPROX_LSB) | (SW'(x | y) & mask);
            end
            2'd2:    res = hi << APPROX_LSB;
            2'd3:    res = (hi << APPROX_LSB) | mask;
            default: res = ex;
        endcase
        return res;
    endfunction

    function automatic logic [WIDTH:0] errOf(input expect_t e);
        return (e.exact >= e.sum) ? (e.exact - e.sum) : (e.sum - e.exact);
    endfunction

    // Drive one cycle of stimulus from a falling edge and observe the
    // handshake before the rising edge. Update the scoreboard and the
    // reference error maximum, then check err_max on the next falling edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] aIn,
                                 input logic [WIDTH-1:0] bIn, input logic [1:0] mIn,
                                 input logic oRdy, input logic clr);
        expect_t        head;
        expect_t        ent;
        logic [WIDTH:0] err;
        logic           delivered;
        in_valid  = v;
        a         = aIn;
        b         = bIn;
        mode      = mIn;
        out_ready = oRdy;
        err_clr   = clr;
        #1;
        obsOutValid  = out_valid;
        obsInReady   = in_ready;
        obsSum       = sum;
        lastAccepted = 1'b0;
        delivered    = 1'b0;
        err          = '0;
        if (!rst) begin
            checkOutput("in_ready", SW'(obsInReady), SW'(!obsOutValid | oRdy));
            if (!obsInReady) sawInReadyLow = 1'b1;
            if (obsOutValid) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("spurious_out", SW'(obsOutValid), SW'(0));
                end else begin
                    head = sbQueue[0];
                    checkOutput(oRdy ? "sum" : "sum_held", obsSum, head.sum);
                    if (oRdy) begin
                        void'(sbQueue.pop_front());
                        delivered = 1'b1;
                        err       = errOf(head);
                    end
                end
            end
            if (clr) errModel = delivered ? err : '0;
            else if (delivered && (err > errModel)) errModel = err;
            if (v && obsInReady) begin
                ent.sum   = modelSum(aIn, bIn, mIn);
                ent.exact = SW'(aIn) + SW'(bIn);
                sbQueue.push_back(ent);
                lastAccepted = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (rst) begin
            sbQueue.delete();
            errModel = '0;
        end else begin
            checkOutput("err_max", err_max, errModel);
        end
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("rst_out_valid", SW'(out_valid), SW'(0));
        checkOutput("rst_sum", sum, SW'(0));
        checkOutput("rst_err_max", err_max, SW'(0));
        checkOutput("rst_in_ready", SW'(in_ready), SW'(1));
        @(negedge clk);
    endtask

    task automatic drainPipe();
        for (int t = 0; t < 20 && sbQueue.size() != 0; t++) begin
            applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
        end
        checkOutput("drain_left", SW'(sbQueue.size()), SW'(0));
    endtask

    // Directed scenarios followed by a randomised stream.
    initial begin
        int sent;
        assertCount   = 0;
        failCount     = 0;
        errModel      = '0;
        sawInReadyLow = 1'b0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        a             = '0;
        b             = '0;
        mode          = 2'd0;
        out_ready     = 1'b1;
        err_clr       = 1'b0;
        @(negedge clk);
        doReset(2);

        // Lower-OR with a guessed carry; result appears two cycles later.
        applyStimulus(1'b1, 16'h00FF, 16'h0081, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
        checkOutput("lat_early", SW'(obsOutValid), SW'(0));
        applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
        checkOutput("lat_due", SW'(obsOutValid), SW'(1));
        checkOutput("lor_sum", obsSum, 17'h001FF);
        checkOutput("lor_err", err_max, 17'h0007F);

        // Truncate raises the worst-case error.
        applyStimulus(1'b1, 16'h12FF, 16'h0101, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
        checkOutput("trunc_sum", obsSum, 17'h01300);
        checkOutput("trunc_err", err_max, 17'h00100);

        // Exact mode with full carry-out leaves err_max alone.
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
        checkOutput("exact_sum", obsSum, 17'h10000);
        checkOutput("exact_err", err_max, 17'h00100);

        // Four back-to-back transactions with downstream stalled mid-stream.
        sawInReadyLow = 1'b0;
        sent          = 0;
        for (int step = 0; step < 30 && (sent < 4 || sbQueue.size() != 0); step++) begin
            applyStimulus(sent < 4, 16'h0F0F + 16'(sent) * 16'h1357,
                          16'h00F3 + 16'(sent) * 16'h2468, 2'(sent),
                          !(step >= 2 && step <= 4), 1'b0);
            if (lastAccepted) sent++;
        end
        checkOutput("stall_in_ready_drop", SW'(sawInReadyLow), SW'(1));
        checkOutput("stream_sent", SW'(sent), SW'(4));
        checkOutput("stream_left", SW'(sbQueue.size()), SW'(0));

        // Reset with two transactions in flight discards both.
        applyStimulus(1'b1, 16'h4444, 16'h3333, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0180, 16'h0080, 2'd3, 1'b1, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("flush_out_valid", SW'(out_valid), SW'(0));
        checkOutput("flush_err_max", err_max, SW'(0));
        checkOutput("flush_sum", sum, SW'(0));
        @(negedge clk);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);

        // Clear coinciding with a saturate-low delivery keeps that error.
        applyStimulus(1'b1, 16'h00FF, 16'h0081, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 2'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
        checkOutput("pre_clr_err", err_max, 17'h0007F);
        applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b1);
        checkOutput("sat_sum", obsSum, 17'h000FF);
        checkOutput("clr_deliver_err", err_max, 17'h000FF);
        applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, 1'b1);
        checkOutput("clr_only", err_max, SW'(0));

        // Random traffic with random stalls, bubbles and clears.
        for (int i = 0; i < 200; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
                          2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0);
        end
        drainPipe();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
